// File: rtl/dmem_mmio_responder.sv
// MMIO peripheral on the core's data-memory port: GPIO out/in with rising-edge
// flags, a down-counting timer with optional auto-reload, and a level interrupt.
module dmem_mmio_responder #(
  parameter logic [31:0] BASE       = 32'h0000_0900,
  parameter int          GPIO_IN_W  = 5,
  parameter int          GPIO_OUT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wd,
  output logic [31:0]           rd,
  output logic                  hit,
  input  logic [GPIO_IN_W-1:0]  gpio_in,
  output logic [GPIO_OUT_W-1:0] gpio_out,
  output logic                  irq
);

  localparam logic [2:0] OFF_GPIO_OUT   = 3'd0;
  localparam logic [2:0] OFF_GPIO_IN    = 3'd1;
  localparam logic [2:0] OFF_EDGE_FLAGS = 3'd2;
  localparam logic [2:0] OFF_TIMER_CTRL = 3'd3;
  localparam logic [2:0] OFF_TIMER_LOAD = 3'd4;
  localparam logic [2:0] OFF_TIMER_CNT  = 3'd5;
  localparam logic [2:0] OFF_IRQ_STATUS = 3'd6;
  localparam logic [2:0] OFF_IRQ_EN     = 3'd7;

  logic [GPIO_OUT_W-1:0] gpio_out_q;
  logic [GPIO_IN_W-1:0]  sync1, sync2, prev, edge_flags;
  logic                  tmr_en, tmr_auto_reload, tmr_exp;
  logic [31:0]           tmr_load, tmr_count;
  logic [1:0]            irq_en;

  logic [2:0]           sel;
  logic                 wr;
  logic                 wr_gpio_out, wr_edge, wr_ctrl, wr_load, wr_status, wr_irq_en;
  logic [GPIO_IN_W-1:0] rise, edge_clr;
  logic                 edge_any, tmr_fire;
  logic [31:0]          rd_word;

  // Word-aligned accesses only; the byte-lane bits carry no meaning here.
  logic unused_byte_lane;
  assign unused_byte_lane = &{1'b0, addr[1:0]};

  assign hit = (addr[31:5] == BASE[31:5]);
  assign sel = addr[4:2];
  assign wr  = we & hit;

  assign wr_gpio_out = wr && (sel == OFF_GPIO_OUT);
  assign wr_edge     = wr && (sel == OFF_EDGE_FLAGS);
  assign wr_ctrl     = wr && (sel == OFF_TIMER_CTRL);
  assign wr_load     = wr && (sel == OFF_TIMER_LOAD);
  assign wr_status   = wr && (sel == OFF_IRQ_STATUS);
  assign wr_irq_en   = wr && (sel == OFF_IRQ_EN);

  assign rise     = sync2 & ~prev;
  assign edge_clr = wr_edge ? wd[GPIO_IN_W-1:0] : '0;
  assign edge_any = |edge_flags;

  // A software LOAD/CTRL write pre-empts the timer step, so it can never expire that cycle.
  assign tmr_fire = tmr_en && (tmr_count == 32'd1) && !wr_load && !wr_ctrl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make sync1->sync2->prev collapse into one stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gpio_out_q <= '0;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      edge_flags <= '0;
      irq_en     <= '0;
    end else begin
      sync1      <= gpio_in;
      sync2      <= sync1;
      prev       <= sync2;
      // Hardware set beats a simultaneous W1C of the same bit.
      edge_flags <= (edge_flags & ~edge_clr) | rise;
      if (wr_gpio_out) gpio_out_q <= wd[GPIO_OUT_W-1:0];
      if (wr_irq_en)   irq_en     <= wd[1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr_en          <= 1'b0;
      tmr_auto_reload <= 1'b0;
      tmr_load        <= '0;
      tmr_count       <= '0;
      tmr_exp         <= 1'b0;
    end else begin
      tmr_exp <= (tmr_exp & ~(wr_status & wd[0])) | tmr_fire;
      if (wr_load) begin
        tmr_load  <= wd;
        tmr_count <= wd;
      end else if (wr_ctrl) begin
        tmr_en          <= wd[0];
        tmr_auto_reload <= wd[1];
      end else if (tmr_fire) begin
        if (tmr_auto_reload) begin
          tmr_count <= tmr_load;
        end else begin
          tmr_count <= '0;
          tmr_en    <= 1'b0;
        end
      end else if (tmr_en && (tmr_count > 32'd1)) begin
        tmr_count <= tmr_count - 32'd1;
      end
    end
  end

  // NOTE: rd_word gets a full default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    unique case (sel)
      OFF_GPIO_OUT:   rd_word[GPIO_OUT_W-1:0] = gpio_out_q;
      OFF_GPIO_IN:    rd_word[GPIO_IN_W-1:0]  = sync2;
      OFF_EDGE_FLAGS: rd_word[GPIO_IN_W-1:0]  = edge_flags;
      OFF_TIMER_CTRL: rd_word[1:0]            = {tmr_auto_reload, tmr_en};
      OFF_TIMER_LOAD: rd_word                 = tmr_load;
      OFF_TIMER_CNT:  rd_word                 = tmr_count;
      OFF_IRQ_STATUS: rd_word[1:0]            = {edge_any, tmr_exp};
      OFF_IRQ_EN:     rd_word[1:0]            = irq_en;
      default:        rd_word                 = '0;
    endcase
  end

  assign rd       = hit ? rd_word : 32'd0;
  assign gpio_out = gpio_out_q;
  assign irq      = |({edge_any, tmr_exp} & irq_en);

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: GPIO, edge flags, timer modes,
// write/expiry priorities, address decode and asynchronous reset.
module tb_dmem_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_0900;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we    = 1'b0;
  logic [31:0] addr  = BASE;
  logic [31:0] wd    = '0;
  logic [31:0] rd;
  logic        hit;
  logic [4:0]  gpio_in = '0;
  logic [15:0] gpio_out;
  logic        irq;

  int tests = 0;
  int fails = 0;

  dmem_mmio_responder #(.BASE(BASE), .GPIO_IN_W(5), .GPIO_OUT_W(16)) dut (
    .clock(clock), .reset(reset), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .hit(hit), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic wr_reg(input logic [4:0] off, input logic [31:0] data);
    addr = BASE + {27'd0, off};
    wd   = data;
    we   = 1'b1;
    @(posedge clock); #1;
    we   = 1'b0;
    wd   = '0;
  endtask

  task automatic rd_reg(input logic [4:0] off, output logic [31:0] data);
    addr = BASE + {27'd0, off};
    we   = 1'b0;
    #1;
    data = rd;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    #2;
    tests++; if (gpio_out !== 16'h0) begin fails++; $display("FAIL reset_gpio_out got=%h exp=0000", gpio_out); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd_reg(5'h14, v);
    tests++; if (hit !== 1'b1 || v !== 32'd0) begin fails++; $display("FAIL reset_count hit=%b got=%h exp=00000000", hit, v); end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_gpio_out;
    logic [31:0] v;
    wr_reg(5'h00, 32'h0000_BEEF);
    tests++; if (gpio_out !== 16'hBEEF) begin fails++; $display("FAIL gpio_out_pin got=%h exp=beef", gpio_out); end
    rd_reg(5'h00, v);
    tests++; if (v !== 32'h0000_BEEF) begin fails++; $display("FAIL gpio_out_read got=%h exp=0000beef", v); end
    reset = 1'b1;
    #1;
    tests++; if (gpio_out !== 16'h0) begin fails++; $display("FAIL gpio_out_async_reset got=%h exp=0000", gpio_out); end
    rd_reg(5'h00, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL gpio_out_read_in_reset got=%h exp=00000000", v); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_gpio_in;
    logic [31:0] v;
    wr_reg(5'h1C, 32'h2);
    gpio_in = 5'b00101;
    tick();
    rd_reg(5'h04, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL gpio_in_edge1 got=%h exp=00000000", v); end
    tick();
    rd_reg(5'h04, v);
    tests++; if (v !== 32'h5) begin fails++; $display("FAIL gpio_in_edge2 got=%h exp=00000005", v); end
    rd_reg(5'h08, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL edge_flags_edge2 got=%h exp=00000000", v); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL edge_irq_edge2 got=%b exp=0", irq); end
    tick();
    rd_reg(5'h08, v);
    tests++; if (v !== 32'h5) begin fails++; $display("FAIL edge_flags_edge3 got=%h exp=00000005", v); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL edge_irq_edge3 got=%b exp=1", irq); end
    rd_reg(5'h18, v);
    tests++; if (v !== 32'h2) begin fails++; $display("FAIL irq_status_edge got=%h exp=00000002", v); end
    wr_reg(5'h08, 32'h1);
    rd_reg(5'h08, v);
    tests++; if (v !== 32'h4) begin fails++; $display("FAIL edge_w1c_bit0 got=%h exp=00000004", v); end
    wr_reg(5'h08, 32'h1F);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL edge_w1c_all_irq got=%b exp=0", irq); end
  endtask

  task automatic test_timer_oneshot;
    logic [31:0] v;
    wr_reg(5'h1C, 32'h1);
    wr_reg(5'h10, 32'd3);
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd3) begin fails++; $display("FAIL oneshot_load_count got=%0d exp=3", v); end
    wr_reg(5'h0C, 32'h1);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL oneshot_irq_e1 got=%b exp=0", irq); end
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd2 || irq !== 1'b0) begin fails++; $display("FAIL oneshot_e2 count=%0d irq=%b exp count=2 irq=0", v, irq); end
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd1 || irq !== 1'b0) begin fails++; $display("FAIL oneshot_e3 count=%0d irq=%b exp count=1 irq=0", v, irq); end
    tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL oneshot_irq_e4 got=%b exp=1", irq); end
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL oneshot_count_end got=%0d exp=0", v); end
    rd_reg(5'h0C, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL oneshot_ctrl_end got=%h exp=00000000", v); end
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL oneshot_hold_zero got=%0d exp=0", v); end
    wr_reg(5'h18, 32'h1);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL oneshot_w1c_irq got=%b exp=0", irq); end
  endtask

  task automatic test_timer_autoreload;
    logic [31:0] v;
    wr_reg(5'h10, 32'd2);
    wr_reg(5'h0C, 32'h3);
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd2) begin fails++; $display("FAIL auto_c0 got=%0d exp=2", v); end
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd1) begin fails++; $display("FAIL auto_c1 got=%0d exp=1", v); end
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd2) begin fails++; $display("FAIL auto_reload got=%0d exp=2", v); end
    rd_reg(5'h18, v);
    tests++; if (v !== 32'h1) begin fails++; $display("FAIL auto_exp_set got=%h exp=00000001", v); end
    wr_reg(5'h18, 32'h1);
    rd_reg(5'h18, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL auto_w1c got=%h exp=00000000", v); end
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd1) begin fails++; $display("FAIL auto_c3 got=%0d exp=1", v); end
    // W1C lands on the expiry edge: the set must survive
    wr_reg(5'h18, 32'h1);
    rd_reg(5'h18, v);
    tests++; if (v !== 32'h1) begin fails++; $display("FAIL auto_set_beats_clear got=%h exp=00000001", v); end
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd2) begin fails++; $display("FAIL auto_c4 got=%0d exp=2", v); end
    wr_reg(5'h18, 32'h1);
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd1) begin fails++; $display("FAIL auto_c5 got=%0d exp=1", v); end
    // LOAD write on the edge where count==1 would expire
    wr_reg(5'h10, 32'd5);
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd5) begin fails++; $display("FAIL load_override_count got=%0d exp=5", v); end
    rd_reg(5'h18, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL load_override_no_exp got=%h exp=00000000", v); end
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd4) begin fails++; $display("FAIL load_override_next got=%0d exp=4", v); end
    wr_reg(5'h0C, 32'h0);
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd4) begin fails++; $display("FAIL ctrl_disable_hold got=%0d exp=4", v); end
  endtask

  task automatic test_window_decode;
    logic [31:0] v;
    wr_reg(5'h00, 32'h0000_1234);
    addr = 32'h0000_01FC;
    wd   = 32'hFFFF_FFFF;
    we   = 1'b1;
    #1;
    tests++; if (hit !== 1'b0 || rd !== 32'd0) begin fails++; $display("FAIL miss_1fc hit=%b rd=%h exp hit=0 rd=00000000", hit, rd); end
    tick();
    we = 1'b0;
    wd = '0;
    tests++; if (gpio_out !== 16'h1234) begin fails++; $display("FAIL miss_no_write got=%h exp=1234", gpio_out); end
    rd_reg(5'h1C, v);
    tests++; if (v !== 32'h1) begin fails++; $display("FAIL miss_irq_en_kept got=%h exp=00000001", v); end
    addr = BASE + 32'h20;
    #1;
    tests++; if (hit !== 1'b0 || rd !== 32'd0) begin fails++; $display("FAIL miss_above hit=%b rd=%h exp hit=0 rd=00000000", hit, rd); end
    addr = BASE + 32'h15;
    #1;
    tests++; if (hit !== 1'b1 || rd !== 32'd4) begin fails++; $display("FAIL unaligned_count hit=%b rd=%0d exp hit=1 rd=4", hit, rd); end
    wr_reg(5'h14, 32'h0000_00AA);
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd4) begin fails++; $display("FAIL count_ro got=%0d exp=4", v); end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] v;
    wr_reg(5'h10, 32'd10);
    wr_reg(5'h0C, 32'h1);
    tick();
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd8) begin fails++; $display("FAIL midcount_pre got=%0d exp=8", v); end
    reset = 1'b1;
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL midcount_reset_count got=%0d exp=0", v); end
    rd_reg(5'h10, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL midcount_reset_load got=%0d exp=0", v); end
    rd_reg(5'h0C, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL midcount_reset_ctrl got=%h exp=00000000", v); end
    tests++; if (gpio_out !== 16'h0 || irq !== 1'b0) begin fails++; $display("FAIL midcount_reset_pins gpio_out=%h irq=%b exp 0000/0", gpio_out, irq); end
    reset = 1'b0;
    tick();
    tick();
    rd_reg(5'h14, v);
    tests++; if (v !== 32'd0) begin fails++; $display("FAIL midcount_after_reset got=%0d exp=0", v); end
  endtask

  initial begin
    test_reset();
    test_gpio_out();
    test_gpio_in();
    test_timer_oneshot();
    test_timer_autoreload();
    test_window_decode();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Memory-mapped peripheral that answers the MIPS core's data-memory port (`dmem_we`, ALU-computed address, `dmem_wd`) for a fixed address window. It owns the SoC's GPIO output register, a synchronized and edge-detected GPIO input, a down-counting timer, and an interrupt line. It sits beside the data RAM in `soc`. Its read data is muxed into the core's load path whenever `hit` is asserted.

## Interface

- `BASE`, default 32'h0000_0900: byte base address of the 32-byte register window; bits [4:0] ignored.
- `GPIO_IN_W`, default 5: width of the GPIO input bus.
- `GPIO_OUT_W`, default 16: width of the GPIO output bus.

Ports:

- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `we`  in  1  data-memory write enable from core
- `addr`  in  32  data-memory byte address (ALU result)
- `wd`  in  32  data-memory write data
- `rd`  out  32  read data, combinational; 0 when `hit`=0
- `hit`  out  1  combinational; `addr[31:5]==BASE[31:5]`
- `gpio_in`  in  GPIO_IN_W  asynchronous external inputs
- `gpio_out`  out  GPIO_OUT_W  registered GPIO outputs
- `irq`  out  1  `|(irq_status & irq_en)`, from registers only

## Operation

- Register offsets are decoded from `addr[4:2]`. `addr[1:0]` is ignored, and all accesses are full-word.
  - 0x00 GPIO_OUT (RW): bits [GPIO_OUT_W-1:0]; upper bits read 0.
  - 0x04 GPIO_IN (RO): 2-flop synchronized value.
  - 0x08 EDGE_FLAGS (W1C): sticky rising-edge flags, one per input.
  - 0x0C TIMER_CTRL (RW): bit0 `en`, bit1 `auto_reload`.
  - 0x10 TIMER_LOAD (RW): 32-bit reload value. A write also loads COUNT.
  - 0x14 TIMER_COUNT (RO): current count.
  - 0x18 IRQ_STATUS: bit0 `tmr_exp`, sticky and W1C; bit1 = `|EDGE_FLAGS`, read-only.
  - 0x1C IRQ_EN (RW): bits [1:0].
- A write occurs when `we & hit` at the clock edge. Writes to RO registers or RO bits are ignored.
- Edge detect uses a `prev` register that captures `sync2` each cycle. A flag is set when `sync2 & ~prev`.
- Timer rules, evaluated per cycle when `en`=1:
  - COUNT>1: COUNT−1.
  - COUNT==1: set `tmr_exp`, and:
    - if `auto_reload`=1, COUNT←LOAD;
    - if `auto_reload`=0, COUNT←0 and `en`←0.
  - COUNT==0: hold, no expiry.
- Priorities for simultaneous events:
  - A software write to LOAD or CTRL wins over the timer update in the same cycle.
  - A hardware set of a sticky bit wins over a W1C clear of the same bit in the same cycle.
  - Writes to unrelated registers never disturb the timer or the flags.
- Reset (asynchronous, at any time, including mid-count): every register is cleared to 0. After reset:
  - `gpio_out`=0, `irq`=0;
  - COUNT=0, LOAD=0, CTRL=0;
  - flags=0, sync and prev flops=0.
- Output values in reset: `rd`/`hit` are combinational. `rd`=0 whenever `hit`=0; otherwise `rd` reflects the zeroed registers.

## Timing

- Read latency is 0 cycles. `rd` is valid in the same cycle as `addr`, matching the single-cycle datapath.
- Write latency is 1 edge. The new value is visible on `rd`/`gpio_out` after the write edge.
- Input pin rise to GPIO_IN read: visible after the 2nd rising edge.
- Input pin rise to EDGE_FLAGS bit: set at the 3rd rising edge. `irq` rises in the same cycle if IRQ_EN bit1=1.
- Timer latency:
  - Write LOAD=N at edge 0, then CTRL.en=1 at edge 1: `tmr_exp` sets at edge 1+N.
  - A LOAD and CTRL write in one transaction is impossible (single port).
- Pulses shorter than one clock may be missed. Each rising edge that is held for at least 1 cycle sets its flag once.

## Test plan

- Reset, then write 32'h0000_BEEF to BASE+0x00 → `gpio_out`=16'hBEEF after 1 edge; read returns 32'h0000_BEEF; assert `reset` mid-run → `gpio_out`=0 immediately.
- Drive `gpio_in`=5'b00101 → GPIO_IN reads 5'h05 after 2 edges, EDGE_FLAGS reads 5'h05 after 3 edges; write 32'h1 to 0x08 → reads 5'h04.
- LOAD=3, CTRL=1 (one-shot), IRQ_EN=1 → `irq` rises exactly 3 edges after CTRL write; COUNT=0, CTRL.en=0; write 1 to 0x18 → `irq`=0.
- LOAD=2, CTRL=3 (auto-reload) → `tmr_exp` sets, COUNT sequence 2,1,2,1,…; W1C issued in the same cycle as an expiry leaves `tmr_exp`=1.
- Access `addr`=0x1FC with `we`=1 → `hit`=0, `rd`=0, no register changes; access BASE+0x15 → decodes as TIMER_COUNT.
- Write LOAD=5 in the same cycle the running count would hit 1 → COUNT=5 next cycle, no expiry that cycle.
